// File: rtl/hook_controller_pkg.sv
// Shared definitions for the gold-miner hook controller: state encoding,
// state width and default swing/length limits.
package hook_controller_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        SWING   = 2'd0,
        EXTEND  = 2'd1,
        RETRACT = 2'd2,
        SCORE   = 2'd3
    } hook_state_t;

    localparam logic [7:0] ANGLE_MAX_DEF = 8'd180;
    localparam logic [7:0] LEN_MAX_DEF   = 8'd200;

endpackage

// File: rtl/hook_controller_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse, one cycle after `in` rises.
module rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic in,
    output logic out_pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev      <= 1'b0;
            out_pulse <= 1'b0;
        end else begin
            prev      <= in;
            out_pulse <= in & ~prev;
        end
    end

endmodule

// File: rtl/hook_controller.sv
// Hook FSM: swings the angle, fires on a key press, extends, then retracts
// with or without a payload; paces every move off the frame counter's step.
module hook_controller
    import hook_controller_pkg::*;
#(
    parameter logic [7:0] ANGLE_MAX = ANGLE_MAX_DEF,
    parameter logic [7:0] LEN_MAX   = LEN_MAX_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               fire,
    input  logic               hit,
    input  logic               heavy,
    input  logic               enable_next,
    output logic               enable_my_counter,
    output logic [7:0]         angle,
    output logic [7:0]         length,
    output logic [STATE_W-1:0] hook_state,
    output logic               loaded,
    output logic               score_pulse
);

    hook_state_t state, state_next;
    logic        step, fire_rise;
    logic        dir_up, swing_up, heavy_l, slow;
    logic        en_next, score_next, retract_entry;

    rise_detect u_fire_rise (
        .clk       (clk),
        .resetn    (resetn),
        .in        (fire),
        .out_pulse (fire_rise)
    );

    rise_detect u_step_rise (
        .clk       (clk),
        .resetn    (resetn),
        .in        (enable_next),
        .out_pulse (step)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state             <= SWING;
            enable_my_counter <= 1'b0;
            score_pulse       <= 1'b0;
        end else begin
            state             <= state_next;
            enable_my_counter <= en_next;
            score_pulse       <= score_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SWING:   if (fire_rise) state_next = EXTEND;
            EXTEND:  if (hit || (step && length == LEN_MAX)) state_next = RETRACT;
            RETRACT: if (length == '0) state_next = loaded ? SCORE : SWING;
            SCORE:   state_next = SWING;
        endcase
    end

    // Outputs are registered from the next state so they line up with hook_state.
    always_comb begin
        en_next       = (state_next == state);
        score_next    = (state_next == SCORE);
        retract_entry = (state_next == RETRACT) && (state != RETRACT);
    end

    assign hook_state = state;

    // Bounce: keep moving the current way unless pinned at the far end.
    assign swing_up = dir_up ? (angle != ANGLE_MAX) : (angle == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            angle   <= '0;
            dir_up  <= 1'b1;
            length  <= '0;
            loaded  <= 1'b0;
            heavy_l <= 1'b0;
            slow    <= 1'b0;
        end else begin
            if (retract_entry)
                slow <= 1'b0;
            unique case (state)
                SWING: begin
                    if (step && !fire_rise) begin
                        dir_up <= swing_up;
                        angle  <= swing_up ? angle + 8'd1 : angle - 8'd1;
                    end
                end
                EXTEND: begin
                    if (hit) begin
                        loaded  <= 1'b1;
                        heavy_l <= heavy;
                    end else if (step && length != LEN_MAX) begin
                        length <= length + 8'd1;
                    end
                end
                RETRACT: begin
                    if (step && length != '0) begin
                        if (loaded && heavy_l) begin
                            slow <= ~slow;
                            if (slow)
                                length <= length - 8'd1;
                        end else begin
                            length <= length - 8'd1;
                        end
                    end
                end
                SCORE: begin
                    loaded  <= 1'b0;
                    heavy_l <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hook_controller.sv
// Directed plus randomized bench for hook_controller; expectations come from
// step counts and closed-form angle/length arithmetic.
module tb_hook_controller;

    localparam int AMAX = 3;
    localparam int LMAX = 6;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       fire = 1'b0;
    logic       hit = 1'b0;
    logic       heavy = 1'b0;
    logic       enable_next = 1'b0;
    logic       enable_my_counter;
    logic [7:0] angle;
    logic [7:0] length;
    logic [1:0] hook_state;
    logic       loaded;
    logic       score_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int n_swing = 0;
    int score_cnt = 0;
    int score_exp = 0;
    int score_bad = 0;
    logic prev_sp = 1'b0;

    always #5 clk = ~clk;

    hook_controller #(
        .ANGLE_MAX (8'd3),
        .LEN_MAX   (8'd6)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .fire              (fire),
        .hit               (hit),
        .heavy             (heavy),
        .enable_next       (enable_next),
        .enable_my_counter (enable_my_counter),
        .angle             (angle),
        .length            (length),
        .hook_state        (hook_state),
        .loaded            (loaded),
        .score_pulse       (score_pulse)
    );

    // Score pulses must be single cycles and only ever seen in SCORE.
    always @(negedge clk) begin
        if (score_pulse === 1'b1) begin
            score_cnt++;
            if (prev_sp === 1'b1 || hook_state !== 2'd3)
                score_bad++;
        end
        prev_sp = score_pulse;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int tri_angle(input int n);
        int m;
        m = n % (2 * AMAX);
        return (m <= AMAX) ? m : 2 * AMAX - m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_step(input bit hit_noise, input bit fire_noise);
        enable_next = 1'b1;
        if (hit_noise)  hit  = 1'($urandom_range(0, 1));
        if (fire_noise) fire = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clk);
        enable_next = 1'b0;
        hit = 1'b0;
        fire = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic swing(input int k);
        for (int i = 0; i < k; i++) begin
            do_step(1'b1, 1'b0);
            n_swing++;
            check("swing_angle", angle, tri_angle(n_swing));
            check("swing_state", hook_state, 0);
        end
    endtask

    task automatic do_fire();
        fire = 1'b1;
        repeat (2) @(negedge clk);
        check("fire_state", hook_state, 1);
        check("fire_en_first", enable_my_counter, 0);
        @(negedge clk);
        check("fire_en_after", enable_my_counter, 1);
        fire = 1'b0;
        @(negedge clk);
    endtask

    // hit_at > LMAX means an empty shot.
    task automatic do_shot(input int hit_at, input bit hv, input bit simul);
        int L;
        int nst;
        int exp_len;
        bit ld;
        bit slowmode;
        if (simul) begin
            fire = 1'b1;
            enable_next = 1'b1;
            repeat (2) @(negedge clk);
            check("simul_state", hook_state, 1);
            check("simul_angle", angle, tri_angle(n_swing));
            @(negedge clk);
            fire = 1'b0;
            enable_next = 1'b0;
            repeat (2) @(negedge clk);
            check("simul_len", length, 0);
        end else begin
            do_fire();
        end
        for (int i = 0; i < hit_at && i < LMAX; i++) begin
            do_step(1'b0, 1'b0);
            check("ext_len", length, i + 1);
            check("ext_state", hook_state, 1);
        end
        if (hit_at <= LMAX) begin
            hit = 1'b1;
            heavy = hv;
            @(negedge clk);
            hit = 1'b0;
            heavy = 1'($urandom_range(0, 1));
            check("grab_state", hook_state, 2);
            check("grab_loaded", loaded, 1);
            check("grab_len", length, hit_at);
            L = hit_at;
            ld = 1'b1;
        end else begin
            do_step(1'b0, 1'b0);
            check("turn_state", hook_state, 2);
            check("turn_loaded", loaded, 0);
            check("turn_len", length, LMAX);
            L = LMAX;
            ld = 1'b0;
        end
        slowmode = ld && hv;
        nst = slowmode ? 2 * L : L;
        if (nst == 0)
            repeat (3) @(negedge clk);
        for (int i = 1; i <= nst; i++) begin
            do_step(1'b1, 1'b1);
            exp_len = slowmode ? L - i / 2 : L - i;
            check("ret_len", length, exp_len);
        end
        if (ld) score_exp++;
        check("end_state", hook_state, 0);
        check("end_loaded", loaded, 0);
        check("end_angle", angle, tri_angle(n_swing));
        check("score_count", score_cnt, score_exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_state", hook_state, 0);
        check("rst_angle", angle, 0);
        check("rst_len", length, 0);
        check("rst_loaded", loaded, 0);
        check("rst_score", score_pulse, 0);
        check("rst_en", enable_my_counter, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_en", enable_my_counter, 1);

        swing(8);
        do_shot(LMAX + 1, 1'b0, 1'b0);
        do_shot(2, 1'b0, 1'b0);
        do_shot(3, 1'b1, 1'b0);
        do_shot(LMAX, 1'b1, 1'b0);
        do_shot(0, 1'b0, 1'b0);
        swing(3);
        do_shot(LMAX + 1, 1'b0, 1'b1);

        swing(2);
        do_fire();
        for (int i = 0; i < 5; i++) do_step(1'b0, 1'b0);
        hit = 1'b1;
        heavy = 1'b0;
        @(negedge clk);
        hit = 1'b0;
        check("mid_state", hook_state, 2);
        check("mid_len", length, 5);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_len", length, 0);
        check("mid_rst_state", hook_state, 0);
        check("mid_rst_loaded", loaded, 0);
        check("mid_rst_angle", angle, 0);
        check("mid_rst_en", enable_my_counter, 0);
        resetn = 1'b1;
        n_swing = 0;
        @(negedge clk);

        for (int r = 0; r < 20; r++) begin
            swing($urandom_range(0, 7));
            do_shot($urandom_range(0, LMAX + 1), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4) == 0);
        end

        check("score_shape", score_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
